// File: rtl/mmio_peripherals.sv
// ---------------------------------------------------------------------------
// mmio_peripherals
//
// Memory-mapped peripheral block that sits beside data memory on the CPU's
// MEM-stage port. It answers loads and stores that fall inside a 32-byte
// window starting at BASE_ADDR and contains:
//   - a reloadable 32-bit timer (TH reload, TL count, TCON control/status)
//     with a level interrupt,
//   - a free-running 32-bit cycle counter (SYSTICK),
//   - an 8-bit LED register,
//   - a four-digit hex display driver that scans the digits in hardware.
//
// Register map (byte offset from BASE_ADDR, Address[4:2] selects):
//   0x00 TH      RW  timer reload value
//   0x04 TL      RW  timer count
//   0x08 TCON    RW  [0] enable, [1] irq enable, [2] irq status
//   0x0C LED     RW  [7:0]
//   0x10 DIGITS  RW  [15:0], four hex nibbles, digit 0 in [3:0]
//   0x14 SYSTICK RO
//   0x18, 0x1C   read as 0, writes ignored
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   MemRead    load strobe
//   MemWrite   store strobe
//   Address    byte address
//   Write_data store data
//   Read_data  load data, combinational; 0 unless a load hits the window
//   irq        timer interrupt request, level (TCON[1] & TCON[2])
//   led        LED register
//   ano        digit anodes, active-low
//   leds       segments {g,f,e,d,c,b,a}, active-low
//
// Bus handshake: there is no wait state. A load with MemRead high and a
// hit returns data in the same cycle; a store with MemWrite high and a hit
// is committed at the next rising clk edge. When both strobes are high the
// load returns the value held before the store commits.
// ---------------------------------------------------------------------------
module mmio_peripherals #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          SCAN_DIV  = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic        irq,
    output logic [7:0]  led,
    output logic [3:0]  ano,
    output logic [6:0]  leds
);

    // Prescaler runs 0..SCAN_DIV-1; SCAN_DIV tops out at 2^20 so 20 bits hold
    // the largest terminal count.
    localparam logic [19:0] PRESC_LAST = 20'(SCAN_DIV - 1);

    localparam logic [2:0] SEL_TH      = 3'd0;
    localparam logic [2:0] SEL_TL      = 3'd1;
    localparam logic [2:0] SEL_TCON    = 3'd2;
    localparam logic [2:0] SEL_LED     = 3'd3;
    localparam logic [2:0] SEL_DIGITS  = 3'd4;
    localparam logic [2:0] SEL_SYSTICK = 3'd5;

    logic [31:0] th;
    logic [31:0] tl;
    logic [2:0]  tcon;
    logic [15:0] digits;
    logic [31:0] systick;
    logic [19:0] presc;
    logic [1:0]  idx;

    logic        hit;
    logic [2:0]  sel;
    logic        wr_th;
    logic        wr_tl;
    logic        wr_tcon;
    logic        wr_led;
    logic        wr_digits;
    logic        tl_max;
    logic        reload;
    logic [31:0] tl_next;
    logic [2:0]  tcon_next;
    logic [3:0]  nibble;
    logic [1:0]  addr_unused;

    // Byte lane bits play no part in decoding.
    assign addr_unused = Address[1:0];

    assign hit       = (Address[31:5] == BASE_ADDR[31:5]);
    assign sel       = Address[4:2];
    assign wr_th     = MemWrite && hit && (sel == SEL_TH);
    assign wr_tl     = MemWrite && hit && (sel == SEL_TL);
    assign wr_tcon   = MemWrite && hit && (sel == SEL_TCON);
    assign wr_led    = MemWrite && hit && (sel == SEL_LED);
    assign wr_digits = MemWrite && hit && (sel == SEL_DIGITS);

    assign tl_max = (tl == 32'hFFFF_FFFF);
    // A CPU store to TL overrides the timer, so no reload (and no status
    // set) happens in a cycle where TL is being written.
    assign reload = tcon[0] && tl_max && !wr_tl;

    always_comb begin
        tl_next = tl;
        if (wr_tl) begin
            tl_next = Write_data;
        end else if (tcon[0]) begin
            tl_next = tl_max ? th : (tl + 32'd1);
        end
    end

    // Status bit: the hardware set is OR-ed in after the CPU value so an
    // overflow in the same cycle as a software clear is never lost.
    always_comb begin
        tcon_next = tcon;
        if (wr_tcon) begin
            tcon_next = Write_data[2:0];
        end
        if (reload && tcon[1]) begin
            tcon_next[2] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th      <= '0;
            tl      <= '0;
            tcon    <= '0;
            led     <= '0;
            digits  <= '0;
            systick <= '0;
            presc   <= '0;
            idx     <= '0;
        end else begin
            systick <= systick + 32'd1;
            tl      <= tl_next;
            tcon    <= tcon_next;
            if (wr_th) begin
                th <= Write_data;
            end
            if (wr_led) begin
                led <= Write_data[7:0];
            end
            if (wr_digits) begin
                digits <= Write_data[15:0];
            end
            if (presc == PRESC_LAST) begin
                presc <= '0;
                idx   <= idx + 2'd1;
            end else begin
                presc <= presc + 20'd1;
            end
        end
    end

    // Load path: registers are read before any same-cycle store commits.
    always_comb begin
        Read_data = 32'h0;
        if (MemRead && hit) begin
            case (sel)
                SEL_TH:      Read_data = th;
                SEL_TL:      Read_data = tl;
                SEL_TCON:    Read_data = {29'h0, tcon};
                SEL_LED:     Read_data = {24'h0, led};
                SEL_DIGITS:  Read_data = {16'h0, digits};
                SEL_SYSTICK: Read_data = systick;
                default:     Read_data = 32'h0;
            endcase
        end
    end

    assign irq = tcon[1] & tcon[2];

    // Display outputs depend only on registers.
    assign ano    = ~(4'b0001 << idx);
    assign nibble = digits[{idx, 2'b00} +: 4];

    always_comb begin
        leds = 7'b1111111;
        case (nibble)
            4'h0: leds = 7'b1000000;
            4'h1: leds = 7'b1111001;
            4'h2: leds = 7'b0100100;
            4'h3: leds = 7'b0110000;
            4'h4: leds = 7'b0011001;
            4'h5: leds = 7'b0010010;
            4'h6: leds = 7'b0000010;
            4'h7: leds = 7'b1111000;
            4'h8: leds = 7'b0000000;
            4'h9: leds = 7'b0010000;
            4'hA: leds = 7'b0001000;
            4'hB: leds = 7'b0000011;
            4'hC: leds = 7'b1000110;
            4'hD: leds = 7'b0100001;
            4'hE: leds = 7'b0000110;
            4'hF: leds = 7'b0001110;
            default: leds = 7'b1111111;
        endcase
    end

endmodule

// File: tb/tb_mmio_peripherals.sv
// ---------------------------------------------------------------------------
// tb_mmio_peripherals
//
// Testbench for mmio_peripherals (SCAN_DIV = 4). A behavioural model of the
// register file, timer, cycle counter and display scan is kept alongside the
// DUT and every output is compared against it on each falling clk edge.
// Directed sequences pin the model with literal values; a randomized bus
// phase then exercises the map broadly.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// on the falling edge.
// ---------------------------------------------------------------------------
module tb_mmio_peripherals;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int          SDIV = 4;

    // ---------------- clock / reset ----------------
    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic [31:0] Read_data;
    logic        irq;
    logic [7:0]  led;
    logic [3:0]  ano;
    logic [6:0]  leds;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    mmio_peripherals #(
        .BASE_ADDR (BASE),
        .SCAN_DIV  (SDIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Address    (Address),
        .Write_data (Write_data),
        .Read_data  (Read_data),
        .irq        (irq),
        .led        (led),
        .ano        (ano),
        .leds       (leds)
    );

    // ---------------- scoreboard counters ----------------
    int compared   = 0;
    int mismatched = 0;
    bit checking   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0]  seg_tab [16];
    logic [31:0] m_th;
    logic [31:0] m_tl;
    logic [2:0]  m_tcon;
    logic [7:0]  m_led;
    logic [15:0] m_digits;
    int          m_cycles;
    logic [1:0]  m_idx;
    logic [31:0] m_read;
    logic        m_hit;
    logic [2:0]  m_sel;
    logic        m_wr;
    logic        m_overflow;

    initial begin
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    end

    assign m_hit = (Address[31:5] == BASE[31:5]);
    assign m_sel = Address[4:2];
    assign m_wr  = MemWrite && m_hit;
    // The timer wraps this cycle unless a store to TL takes precedence.
    assign m_overflow = m_tcon[0] && (m_tl == 32'hFFFF_FFFF) && !(m_wr && m_sel == 3'd1);
    // Digit shown = number of whole SCAN_DIV periods since reset, mod 4.
    assign m_idx = 2'((m_cycles / SDIV) % 4);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_th     <= '0;
            m_tl     <= '0;
            m_tcon   <= '0;
            m_led    <= '0;
            m_digits <= '0;
            m_cycles <= 0;
        end else begin
            m_cycles <= m_cycles + 1;
            if (m_wr && m_sel == 3'd0) m_th <= Write_data;
            if (m_wr && m_sel == 3'd1) m_tl <= Write_data;
            else if (m_tcon[0])        m_tl <= m_overflow ? m_th : m_tl + 32'd1;
            if (m_wr && m_sel == 3'd2)
                m_tcon <= {Write_data[2] | (m_overflow & m_tcon[1]), Write_data[1:0]};
            else
                m_tcon <= {m_tcon[2] | (m_overflow & m_tcon[1]), m_tcon[1:0]};
            if (m_wr && m_sel == 3'd3) m_led    <= Write_data[7:0];
            if (m_wr && m_sel == 3'd4) m_digits <= Write_data[15:0];
        end
    end

    always_comb begin
        m_read = 32'h0;
        if (MemRead && m_hit) begin
            case (m_sel)
                3'd0:    m_read = m_th;
                3'd1:    m_read = m_tl;
                3'd2:    m_read = {29'h0, m_tcon};
                3'd3:    m_read = {24'h0, m_led};
                3'd4:    m_read = {16'h0, m_digits};
                3'd5:    m_read = 32'(m_cycles);
                default: m_read = 32'h0;
            endcase
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (checking) begin
            check("read_data", Read_data, m_read);
            check("irq", {31'h0, irq}, {31'h0, m_tcon[1] & m_tcon[2]});
            check("led", {24'h0, led}, {24'h0, m_led});
            check("ano", {28'h0, ano}, {28'h0, ~(4'b0001 << m_idx)});
            check("leds", {25'h0, leds}, {25'h0, seg_tab[m_digits[{m_idx, 2'b00} +: 4]]});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        Address    = a;
        Write_data = d;
        MemWrite   = 1'b1;
        MemRead    = 1'b0;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        Address  = a;
        MemRead  = 1'b1;
        MemWrite = 1'b0;
        @(negedge clk);
        d = Read_data;
        @(posedge clk);
        #1;
        MemRead = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    logic [31:0] rd_a;
    logic [31:0] rd_b;
    logic [6:0]  exp_seg [4];
    logic [3:0]  exp_ano [4];

    initial begin
        exp_seg = '{7'b0001110, 7'b0110000, 7'b0001000, 7'b1111001};
        exp_ano = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

        reset      = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        Address    = '0;
        Write_data = '0;
        #1 reset = 1'b1;
        #2;
        checking = 1'b1;
        check("rst_ano", {28'h0, ano}, 32'hE);
        check("rst_leds", {25'h0, leds}, 32'h40);
        check("rst_led", {24'h0, led}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_read", Read_data, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        // SYSTICK advances once per cycle; other registers read 0.
        bus_read(BASE + 32'h14, rd_a);
        repeat (4) idle();
        bus_read(BASE + 32'h14, rd_b);
        check("systick_delta", rd_b - rd_a, 32'd5);
        for (int k = 0; k < 8; k++) begin
            if (k != 5) begin
                bus_read(BASE + 32'(k * 4), rd_a);
                check("reset_reg_zero", rd_a, 32'h0);
            end
        end

        // Timer reload and interrupt.
        bus_write(BASE + 32'h00, 32'hFFFF_FFF0);
        bus_write(BASE + 32'h04, 32'hFFFF_FFFE);
        bus_write(BASE + 32'h08, 32'h3);
        bus_read(BASE + 32'h04, rd_a);
        check("tl_before_max", rd_a, 32'hFFFF_FFFE);
        bus_read(BASE + 32'h04, rd_a);
        check("tl_at_max", rd_a, 32'hFFFF_FFFF);
        bus_read(BASE + 32'h04, rd_a);
        check("tl_reloaded", rd_a, 32'hFFFF_FFF0);
        bus_read(BASE + 32'h08, rd_a);
        check("tcon_status", rd_a, 32'h7);
        check("irq_set", {31'h0, irq}, 32'h1);
        bus_write(BASE + 32'h08, 32'h3);
        check("irq_cleared", {31'h0, irq}, 32'h0);
        bus_read(BASE + 32'h08, rd_a);
        check("tcon_cleared", rd_a, 32'h3);

        // Hardware status set wins over a same-cycle software clear.
        bus_write(BASE + 32'h08, 32'h2);
        bus_write(BASE + 32'h04, 32'hFFFF_FFFF);
        bus_write(BASE + 32'h08, 32'h3);
        bus_write(BASE + 32'h08, 32'h2);
        bus_read(BASE + 32'h08, rd_a);
        check("tcon_set_wins", rd_a, 32'h6);
        check("irq_set_wins", {31'h0, irq}, 32'h1);
        bus_read(BASE + 32'h04, rd_a);
        check("tl_after_race", rd_a, 32'hFFFF_FFF0);
        bus_write(BASE + 32'h08, 32'h0);

        // Display scan of 1A3F with SCAN_DIV = 4.
        bus_write(BASE + 32'h10, 32'h0000_1A3F);
        begin
            logic [3:0] prev;
            bit         found;
            prev  = ano;
            found = 1'b0;
            for (int i = 0; i < 20 && !found; i++) begin
                @(negedge clk);
                if (ano == 4'b1110 && prev != 4'b1110) found = 1'b1;
                else prev = ano;
            end
            check("scan_sync", {31'h0, found}, 32'h1);
            for (int j = 0; j < 20; j++) begin
                check("scan_ano", {28'h0, ano}, {28'h0, exp_ano[(j / 4) % 4]});
                check("scan_leds", {25'h0, leds}, {25'h0, exp_seg[(j / 4) % 4]});
                @(negedge clk);
            end
            @(posedge clk);
            #1;
        end

        // Missed stores and loads.
        bus_write(BASE + 32'h20, 32'hDEAD_BEEF);
        bus_write(32'h0000_000C, 32'hDEAD_BEEF);
        bus_read(32'h0000_000C, rd_a);
        check("miss_read_low", rd_a, 32'h0);
        bus_read(BASE + 32'h20, rd_a);
        check("miss_read_above", rd_a, 32'h0);
        bus_read(BASE + 32'h0C, rd_a);
        check("led_unchanged", rd_a, 32'h0);
        bus_read(BASE + 32'h10, rd_a);
        check("digits_unchanged", rd_a, 32'h0000_1A3F);
        bus_write(BASE + 32'h0C, 32'h0000_01A5);
        check("led_out", {24'h0, led}, 32'hA5);
        bus_read(BASE + 32'h0C, rd_a);
        check("led_readback", rd_a, 32'h0000_00A5);

        // Load and store together: load sees the old value.
        Address    = BASE + 32'h0C;
        Write_data = 32'h33;
        MemRead    = 1'b1;
        MemWrite   = 1'b1;
        @(negedge clk);
        check("rw_old_value", Read_data, 32'h0000_00A5);
        @(posedge clk);
        #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        check("rw_new_led", {24'h0, led}, 32'h33);

        // Randomized bus traffic, checked every cycle by the model.
        for (int i = 0; i < 400; i++) begin
            logic [2:0] s;
            s = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) < 8) Address = BASE + {27'h0, s, 2'($urandom_range(0, 3))};
            else if ($urandom_range(0, 1) == 1) Address = BASE + 32'h20 + 32'($urandom_range(0, 31));
            else Address = $urandom;
            MemRead  = 1'($urandom_range(0, 1));
            MemWrite = ($urandom_range(0, 3) == 0);
            case (Address[4:2])
                3'd1:    Write_data = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                3'd2:    Write_data = {$urandom_range(0, 1) == 1 ? 29'h0 : 29'($urandom), 3'($urandom_range(0, 7)) | 3'b001};
                default: Write_data = $urandom;
            endcase
            idle();
        end
        MemRead  = 1'b0;
        MemWrite = 1'b0;

        // Asynchronous reset in the middle of counting and scanning.
        bus_write(BASE + 32'h00, 32'h0);
        bus_write(BASE + 32'h04, 32'hFFFF_FFFF);
        bus_write(BASE + 32'h08, 32'h3);
        idle();
        idle();
        check("irq_before_reset", {31'h0, irq}, 32'h1);
        bus_write(BASE + 32'h0C, 32'hFF);
        Address = BASE + 32'h14;
        MemRead = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("async_ano", {28'h0, ano}, 32'hE);
        check("async_leds", {25'h0, leds}, 32'h40);
        check("async_led", {24'h0, led}, 32'h0);
        check("async_irq", {31'h0, irq}, 32'h0);
        check("async_systick", Read_data, 32'h0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        MemRead = 1'b0;
        repeat (3) idle();
        bus_read(BASE + 32'h14, rd_a);
        check("systick_resume", rd_a, 32'd3);
        bus_read(BASE + 32'h04, rd_a);
        check("tl_after_reset", rd_a, 32'h0);

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
